// File: rtl/usb_pkt_fifo.sv
// usb_pkt_fifo: store-and-forward packet FIFO with SOP/EOP sideband.
// Words are released downstream only once their packet's EOP is committed.
// A partially written packet is rolled back on cancel, on a SOP restart,
// or when it can never fit in storage (oversize).
//
// Handshake semantics: a word moves on a port in any cycle where that
// port's valid and ready are both high at the rising clock edge. up_ready
// is a function of registered state only. dn_valid never depends on dn_ready.
module usb_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_sop,
  input  logic              up_eop,
  input  logic              up_cancel,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic              dn_sop,
  output logic              dn_eop,
  output logic [AW-1:0]     pkt_cnt,
  output logic [AW-1:0]     level,
  output logic              drop_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PKT     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [AW-1:0] DEPTH_P = AW'(DEPTH);

  // Storage entry layout: {sop, eop, data}
  logic [DATA_W+1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_commit_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_pkt_cnt;
  logic              r_drop_err;
  logic              r_rst_done;

  logic [AW-1:0]     w_used;
  logic              w_full;
  logic              w_oversize;
  logic              w_up_hs;
  logic              w_dn_hs;
  logic [DATA_W+1:0] w_rd_word;
  logic              w_pop_eop;

  logic              w_wr_en;
  logic [AW-2:0]     w_wr_addr;
  logic [AW-1:0]     w_wr_ptr_nxt;
  logic [AW-1:0]     w_commit_ptr_nxt;
  state_t            w_state_nxt;
  logic              w_drop_nxt;
  logic              w_commit;

  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_used == DEPTH_P);
  // Storage is full of one in-progress packet with nothing committed ahead
  // of it: no read can ever free space for this packet.
  assign w_oversize = (r_state == S_PKT) && w_full && (r_commit_ptr == r_rd_ptr);

  // DISCARD swallows words regardless of fill; otherwise stall when full.
  assign up_ready = r_rst_done && ((r_state == S_DISCARD) || !w_full);
  assign w_up_hs  = up_valid && up_ready;

  assign dn_valid  = (r_rd_ptr != r_commit_ptr);
  assign w_dn_hs   = dn_valid && dn_ready;
  assign w_rd_word = r_mem[r_rd_ptr[AW-2:0]];
  assign w_pop_eop = w_dn_hs && w_rd_word[DATA_W];

  assign dn_data   = w_rd_word[DATA_W-1:0];
  assign dn_eop    = w_rd_word[DATA_W];
  assign dn_sop    = w_rd_word[DATA_W+1];
  assign level     = w_used;
  assign pkt_cnt   = r_pkt_cnt;
  assign drop_err  = r_drop_err;
  assign dbg_state = r_state;

  // Write-side next state: pointer moves, commits, rollbacks and FSM transitions
  always_comb begin
    w_wr_en          = 1'b0;
    w_wr_addr        = r_wr_ptr[AW-2:0];
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_state_nxt      = r_state;
    w_drop_nxt       = 1'b0;
    w_commit         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Words without SOP are dropped silently; cancel has no effect here.
        if (w_up_hs && up_sop) begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          if (up_eop) begin
            w_commit         = 1'b1;
            w_commit_ptr_nxt = r_wr_ptr + 1'b1;
          end else begin
            w_state_nxt = S_PKT;
          end
        end
      end
      S_PKT: begin
        if (up_cancel) begin
          // Cancel wins over any word in the same cycle, EOP included.
          w_wr_ptr_nxt = r_commit_ptr;
          w_state_nxt  = S_IDLE;
        end else if (w_oversize) begin
          w_wr_ptr_nxt = r_commit_ptr;
          w_state_nxt  = S_DISCARD;
          w_drop_nxt   = 1'b1;
        end else if (w_up_hs) begin
          if (up_sop) begin
            // Restart: discard the partial packet and write the SOP word
            // at the rollback point.
            w_drop_nxt   = 1'b1;
            w_wr_en      = 1'b1;
            w_wr_addr    = r_commit_ptr[AW-2:0];
            w_wr_ptr_nxt = r_commit_ptr + 1'b1;
            if (up_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_commit_ptr + 1'b1;
              w_state_nxt      = S_IDLE;
            end
          end else begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (up_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_wr_ptr + 1'b1;
              w_state_nxt      = S_IDLE;
            end
          end
        end
      end
      S_DISCARD: begin
        if (up_cancel) begin
          w_state_nxt = S_IDLE;
        end else if (w_up_hs) begin
          // A SOP word can only start a new packet if there is room; when
          // storage is full of committed data it is swallowed like the rest.
          if (up_sop && !w_full) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (up_eop) begin
              w_commit         = 1'b1;
              w_commit_ptr_nxt = r_wr_ptr + 1'b1;
              w_state_nxt      = S_IDLE;
            end else begin
              w_state_nxt = S_PKT;
            end
          end else if (up_eop) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered control state, pointers, packet count and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_drop_err   <= 1'b0;
      r_rst_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_drop_err   <= w_drop_nxt;
      r_rst_done   <= 1'b1;
      if (w_dn_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_commit, w_pop_eop})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Storage array write port; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= {up_sop, up_eop, up_data};
    end
  end

endmodule
